round_judge: RTL and testbench

- Receiving end of the per-player card hand-out path.
- Takes each player's registered 4-bit binary card code and decodes it back to one-hot.
- Rebuilds each player's used-card mask and rejects illegal plays.
- Compares the two cards each round, keeps scores and a round counter, and declares the game winner after the last round.
- Sits between the two player hand-out blocks and the display/LED logic.

---
 rtl/round_judge_pkg.sv | 14 +
 rtl/round_judge_if.sv | 17 +
 rtl/round_judge_card_decoder.sv | 13 +
 rtl/round_judge.sv | 112 +++++++++++
 tb/tb_round_judge.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/round_judge_pkg.sv
// round_judge_pkg: state encoding, result codes, default sizes and a three-way compare helper
package round_judge_pkg;
  typedef enum logic [1:0] {S_COLLECT = 2'd0, S_JUDGE = 2'd1, S_SHOW = 2'd2, S_DONE = 2'd3} state_e;
  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1 = 2'b01;
  localparam logic [1:0] RES_P2 = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;
  localparam int NUM_CARDS_DEF = 9;
  localparam int NUM_ROUNDS_DEF = 9;
  localparam int SHOW_CYCLES_DEF = 4;
  function automatic logic [1:0] compare_res(input logic [15:0] a, input logic [15:0] b);
    return a > b ? RES_P1 : a < b ? RES_P2 : RES_DRAW;
  endfunction
endpackage

// File: rtl/round_judge_if.sv
// round_judge_if: player hand-out strobes/cards in, judge status and scores out
interface round_judge_if #(parameter int NUM_CARDS = round_judge_pkg::NUM_CARDS_DEF);
  logic p1_valid, p2_valid, p1_ready, p2_ready, p1_err, p2_err, result_valid, game_over;
  logic [3:0] p1_handcard, p2_handcard, p1_score, p2_score, round_cnt;
  logic [NUM_CARDS-1:0] p1_used, p2_used;
  logic [1:0] round_result, winner;
  modport master (
    output p1_valid, p1_handcard, p2_valid, p2_handcard,
    input p1_ready, p2_ready, p1_err, p2_err, p1_used, p2_used, round_result, result_valid,
    input p1_score, p2_score, round_cnt, game_over, winner
  );
  modport slave (
    input p1_valid, p1_handcard, p2_valid, p2_handcard,
    output p1_ready, p2_ready, p1_err, p2_err, p1_used, p2_used, round_result, result_valid,
    output p1_score, p2_score, round_cnt, game_over, winner
  );
endinterface

// File: rtl/round_judge_card_decoder.sv
// round_judge_card_decoder: 4-bit card code to one-hot, flagging codes beyond the deck
module round_judge_card_decoder #(
  parameter int NUM_CARDS = 9
) (
  input  logic [3:0]           code_i,
  output logic [NUM_CARDS-1:0] onehot_o,
  output logic                 out_of_range_o
);
  always_comb begin
    out_of_range_o = int'(code_i) >= NUM_CARDS;
    onehot_o = out_of_range_o ? '0 : NUM_CARDS'(1) << code_i;
  end
endmodule

// File: rtl/round_judge.sv
// round_judge: validates each player's card, judges rounds, keeps score and declares the game winner
module round_judge import round_judge_pkg::*; #(
  parameter int NUM_CARDS = NUM_CARDS_DEF,
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int SHOW_CYCLES = SHOW_CYCLES_DEF
) (
  input logic clk,
  input logic resetn,
  round_judge_if.slave bus
);
  localparam int SW = $clog2(SHOW_CYCLES + 1);
  state_e state_q, state_d;
  logic [1:0] got_q, got_d, err_q, err_d, ready, valid, oor;
  logic [1:0][3:0] code, score_q, score_d;
  logic [1:0][NUM_CARDS-1:0] onehot, card_q, card_d, used_q, used_d;
  logic [3:0] round_q, round_d;
  logic [1:0] res_q, res_d;
  logic rv_q, rv_d;
  logic [SW-1:0] show_q, show_d;
  assign valid = {bus.p2_valid, bus.p1_valid};
  assign code = {bus.p2_handcard, bus.p1_handcard};
  round_judge_card_decoder #(.NUM_CARDS(NUM_CARDS)) u_dec_p1 (
    .code_i(code[0]), .onehot_o(onehot[0]), .out_of_range_o(oor[0])
  );
  round_judge_card_decoder #(.NUM_CARDS(NUM_CARDS)) u_dec_p2 (
    .code_i(code[1]), .onehot_o(onehot[1]), .out_of_range_o(oor[1])
  );
  assign ready = state_q == S_COLLECT ? ~got_q : 2'b00;
  always_comb begin
    state_d = state_q;
    got_d = got_q;
    err_d = '0;
    card_d = card_q;
    used_d = used_q;
    score_d = score_q;
    round_d = round_q;
    res_d = res_q;
    rv_d = 1'b0;
    show_d = show_q;
    case (state_q)
      S_COLLECT: begin
        for (int i = 0; i < 2; i++) begin
          if (valid[i] && ready[i]) begin
            if (oor[i] || |(onehot[i] & used_q[i])) err_d[i] = 1'b1;
            else begin
              got_d[i] = 1'b1;
              card_d[i] = onehot[i];
            end
          end
        end
        state_d = &got_d ? S_JUDGE : S_COLLECT;
      end
      S_JUDGE: begin
        // a larger one-hot value is exactly a larger card code
        res_d = compare_res(16'(card_q[0]), 16'(card_q[1]));
        score_d[0] = (res_d == RES_P1 && score_q[0] < 4'(NUM_ROUNDS)) ? score_q[0] + 4'd1 : score_q[0];
        score_d[1] = (res_d == RES_P2 && score_q[1] < 4'(NUM_ROUNDS)) ? score_q[1] + 4'd1 : score_q[1];
        used_d[0] = used_q[0] | card_q[0];
        used_d[1] = used_q[1] | card_q[1];
        round_d = round_q < 4'(NUM_ROUNDS) ? round_q + 4'd1 : round_q;
        got_d = '0;
        rv_d = 1'b1;
        show_d = '0;
        state_d = round_d == 4'(NUM_ROUNDS) ? S_DONE : S_SHOW;
      end
      S_SHOW: begin
        show_d = show_q + SW'(1);
        state_d = show_q == SW'(SHOW_CYCLES - 1) ? S_COLLECT : S_SHOW;
        res_d = show_q == SW'(SHOW_CYCLES - 1) ? RES_NONE : res_q;
      end
      S_DONE: state_d = S_DONE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_COLLECT;
      got_q <= '0;
      err_q <= '0;
      card_q <= '0;
      used_q <= '0;
      score_q <= '0;
      round_q <= '0;
      res_q <= RES_NONE;
      rv_q <= 1'b0;
      show_q <= '0;
    end else begin
      state_q <= state_d;
      got_q <= got_d;
      err_q <= err_d;
      card_q <= card_d;
      used_q <= used_d;
      score_q <= score_d;
      round_q <= round_d;
      res_q <= res_d;
      rv_q <= rv_d;
      show_q <= show_d;
    end
  end
  assign bus.p1_ready = ready[0];
  assign bus.p2_ready = ready[1];
  assign bus.p1_err = err_q[0];
  assign bus.p2_err = err_q[1];
  assign bus.p1_used = used_q[0];
  assign bus.p2_used = used_q[1];
  assign bus.round_result = res_q;
  assign bus.result_valid = rv_q;
  assign bus.p1_score = score_q[0];
  assign bus.p2_score = score_q[1];
  assign bus.round_cnt = round_q;
  assign bus.game_over = state_q == S_DONE;
  assign bus.winner = state_q == S_DONE ? compare_res(16'(score_q[0]), 16'(score_q[1])) : RES_NONE;
endmodule

// File: tb/tb_round_judge.sv
// tb_round_judge: directed vector table, hand sequences and a random game against a card-set model
module tb_round_judge;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;
  round_judge_if bus ();
  round_judge dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    bit v1;
    int c1;
    bit v2;
    int c2;
    logic [1:0] err;
    logic [1:0] res;
  } vec_t;
  bit m_used [2][16];
  bit m_got [2];
  int m_card [2];
  int m_score [2];
  int m_round;
  int m_phase;
  logic [1:0] m_res;
  vec_t tbl [12];
  logic [1:0] e, r;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  function automatic logic [1:0] outcome(input int a, input int b);
    return a > b ? 2'b01 : a < b ? 2'b10 : 2'b11;
  endfunction
  function automatic logic [8:0] mask(input int p);
    logic [8:0] m = '0;
    for (int k = 0; k < 9; k++) m[k] = m_used[p][k];
    return m;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 16; k++) m_used[i][k] = 0;
      m_got[i] = 0;
      m_card[i] = 0;
      m_score[i] = 0;
    end
    m_round = 0;
    m_phase = 0;
    m_res = 2'b00;
  endtask
  task automatic check_reset();
    chk("rst_p1_ready", bus.p1_ready, 1);
    chk("rst_p2_ready", bus.p2_ready, 1);
    chk("rst_err", {bus.p2_err, bus.p1_err}, 0);
    chk("rst_p1_used", bus.p1_used, 0);
    chk("rst_p2_used", bus.p2_used, 0);
    chk("rst_result", {bus.result_valid, bus.round_result}, 0);
    chk("rst_scores", {bus.p2_score, bus.p1_score}, 0);
    chk("rst_round_cnt", bus.round_cnt, 0);
    chk("rst_done", {bus.game_over, bus.winner}, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    bus.p1_valid = 0;
    bus.p2_valid = 0;
    #2 resetn = 0;
    #1 check_reset();
    @(negedge clk);
    resetn = 1;
    model_reset();
  endtask
  task automatic step(input bit v1, input int c1, input bit v2, input int c2,
                      output logic [1:0] eo, output logic [1:0] ro);
    bit v [2];
    int c [2];
    bit rdy [2];
    bit xerr [2];
    v[0] = v1; v[1] = v2; c[0] = c1; c[1] = c2;
    @(negedge clk);
    for (int i = 0; i < 2; i++) rdy[i] = m_phase == 0 && !m_got[i];
    chk("p1_ready", bus.p1_ready, 16'(rdy[0]));
    chk("p2_ready", bus.p2_ready, 16'(rdy[1]));
    bus.p1_valid = v1; bus.p1_handcard = 4'(c1);
    bus.p2_valid = v2; bus.p2_handcard = 4'(c2);
    @(negedge clk);
    bus.p1_valid = 0;
    bus.p2_valid = 0;
    for (int i = 0; i < 2; i++) begin
      xerr[i] = 0;
      if (v[i] && rdy[i]) begin
        if (c[i] < 9 && !m_used[i][c[i]]) begin
          m_got[i] = 1;
          m_card[i] = c[i];
        end else xerr[i] = 1;
      end
    end
    chk("p1_err", bus.p1_err, 16'(xerr[0]));
    chk("p2_err", bus.p2_err, 16'(xerr[1]));
    eo = {bus.p2_err, bus.p1_err};
    ro = 2'b00;
    if (m_phase == 0 && m_got[0] && m_got[1]) begin
      chk("judge_rv_low", bus.result_valid, 0);
      chk("judge_ready", {bus.p2_ready, bus.p1_ready}, 0);
      @(negedge clk);
      m_res = outcome(m_card[0], m_card[1]);
      if (m_res == 2'b01) m_score[0]++;
      if (m_res == 2'b10) m_score[1]++;
      for (int i = 0; i < 2; i++) begin
        m_used[i][m_card[i]] = 1;
        m_got[i] = 0;
      end
      m_round++;
      m_phase = m_round == 9 ? 2 : 1;
      chk("result_valid", bus.result_valid, 1);
      chk("round_result", bus.round_result, m_res);
      chk("p1_score", bus.p1_score, 16'(m_score[0]));
      chk("p2_score", bus.p2_score, 16'(m_score[1]));
      chk("round_cnt", bus.round_cnt, 16'(m_round));
      chk("p1_used", bus.p1_used, mask(0));
      chk("p2_used", bus.p2_used, mask(1));
      ro = bus.round_result;
    end
  endtask
  task automatic show_phase();
    int u = 0;
    while (u < 8 && m_used[0][u]) u++;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(negedge clk);
        chk("show_rv_low", bus.result_valid, 0);
        chk("show_err", {bus.p2_err, bus.p1_err}, 0);
      end
      chk("show_ready", {bus.p2_ready, bus.p1_ready}, 0);
      chk("show_hold", bus.round_result, m_res);
      bus.p1_valid = 1; bus.p1_handcard = 4'(u);
      bus.p2_valid = 1; bus.p2_handcard = 4'd15;
    end
    @(negedge clk);
    bus.p1_valid = 0;
    bus.p2_valid = 0;
    chk("collect_ready", {bus.p2_ready, bus.p1_ready}, 2'b11);
    chk("collect_res", bus.round_result, 0);
    chk("collect_err", {bus.p2_err, bus.p1_err}, 0);
    m_phase = 0;
  endtask
  task automatic play(input bit v1, input int c1, input bit v2, input int c2,
                      output logic [1:0] eo, output logic [1:0] ro);
    step(v1, c1, v2, c2, eo, ro);
    if (m_phase == 1) show_phase();
  endtask
  task automatic check_done();
    chk("game_over", bus.game_over, 1);
    chk("winner", bus.winner, outcome(m_score[0], m_score[1]));
    chk("done_ready", {bus.p2_ready, bus.p1_ready}, 0);
    chk("done_res", bus.round_result, m_res);
  endtask
  initial begin
    tbl[0] = '{1'b1, 5, 1'b0, 0, 2'b00, 2'b00};
    tbl[1] = '{1'b0, 0, 1'b1, 3, 2'b00, 2'b01};
    tbl[2] = '{1'b1, 4, 1'b1, 4, 2'b00, 2'b11};
    tbl[3] = '{1'b1, 5, 1'b0, 0, 2'b01, 2'b00};
    tbl[4] = '{1'b1, 9, 1'b0, 0, 2'b01, 2'b00};
    tbl[5] = '{1'b1, 2, 1'b0, 0, 2'b00, 2'b00};
    tbl[6] = '{1'b0, 0, 1'b1, 6, 2'b00, 2'b10};
    tbl[7] = '{1'b0, 0, 1'b1, 7, 2'b00, 2'b00};
    tbl[8] = '{1'b0, 0, 1'b1, 8, 2'b00, 2'b00};
    tbl[9] = '{1'b1, 0, 1'b0, 0, 2'b00, 2'b10};
    tbl[10] = '{1'b1, 15, 1'b1, 15, 2'b11, 2'b00};
    tbl[11] = '{1'b1, 1, 1'b1, 0, 2'b00, 2'b01};
    bus.p1_valid = 0; bus.p1_handcard = 0;
    bus.p2_valid = 0; bus.p2_handcard = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset();
    resetn = 1;
    for (int i = 0; i < 12; i++) begin
      play(tbl[i].v1, tbl[i].c1, tbl[i].v2, tbl[i].c2, e, r);
      chk($sformatf("tbl%0d_err", i), e, tbl[i].err);
      chk($sformatf("tbl%0d_res", i), r, tbl[i].res);
    end
    chk("tbl_p2_used", bus.p2_used, 9'h0d9);
    for (int n = 0; n < 3000 && m_phase != 2; n++)
      play(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), e, r);
    chk("rand_game_over", bus.game_over, 1);
    check_done();
    step(1, 8, 1, 8, e, r);
    chk("done_no_err", e, 0);
    chk("done_round_cnt", bus.round_cnt, 9);
    do_reset();
    for (int k = 0; k < 8; k++) begin
      play(1, k, 1, k + 1, e, r);
      chk($sformatf("g2_round%0d_res", k), r, 2'b10);
    end
    play(1, 8, 1, 0, e, r);
    chk("g2_last_res", r, 2'b01);
    check_done();
    chk("g2_winner", bus.winner, 2'b10);
    chk("g2_p2_score", bus.p2_score, 8);
    step(1, 0, 1, 1, e, r);
    chk("g2_after_done_err", e, 0);
    chk("g2_still_over", bus.game_over, 1);
    do_reset();
    play(1, 1, 1, 2, e, r);
    play(1, 3, 1, 4, e, r);
    step(1, 5, 1, 6, e, r);
    chk("g3_round3_res", r, 2'b10);
    #2 resetn = 0;
    #1 check_reset();
    @(negedge clk);
    resetn = 1;
    model_reset();
    play(1, 0, 1, 0, e, r);
    chk("g3_fresh_res", r, 2'b11);
    chk("g3_fresh_round_cnt", bus.round_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
